mips_main_control_fsm: RTL
==========================

Name: mips_main_control_fsm

Overview:
Multicycle MIPS main controller, directly upstream of alu_control_unit. Sequences each instruction through fetch/decode/execute/memory/writeback states. Drives alu_opcode[1:0] into alu_control_unit, plus all datapath enables and muxes. Handshakes with a unified instruction/data memory that can stall.

Parameters:
OPW, 6, opcode field width (instr[31:26])
STW, 4, state register width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
opcode  in  6  instruction opcode from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes request this cycle
mem_req  out  1  memory access request
mem_we  out  1  memory write (valid with mem_req)
iord  out  1  address mux: 0=PC, 1=ALUOut
ir_write  out  1  load IR
pc_write_en  out  1  PC load, already includes the branch & zero term
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
alu_opcode  out  2  to alu_control_unit
reg_write  out  1  register file write
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
illegal_op  out  1  one-cycle pulse on unknown opcode
state_o  out  STW  current state, debug

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- rst high at a rising edge -> state=FETCH.
- While rst is high, all outputs are combinationally forced inactive: every 1-bit output is 0, pc_src=00, alu_src_b=00, alu_opcode=2'b11.
- Outputs are Moore, decoded from the state. Exceptions:
  - pc_write_en and ir_write in FETCH also depend on mem_ready.
  - pc_write_en in BEQ_EX depends on zero.
- Default output values: 0 / 00; alu_opcode=11.
- alu_opcode encodings:
  - 11 = ADD (alu_ctrl 000)
  - 01 = SUB (001)
  - 10 = SLTI op (100)
  - 00 = use funct
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, SLTI 001010, J 000010.
- States and transitions:
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_opcode=11, pc_src=00. If mem_ready: ir_write=1, pc_write_en=1, next=DECODE. Otherwise stay with ir_write=pc_write_en=0.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_opcode=11 (branch target into ALUOut). Next by opcode:
    - LW/SW -> MEM_ADR
    - RTYPE -> RTYPE_EX
    - BEQ -> BEQ_EX
    - ADDI/SLTI -> IMM_EX
    - J -> JUMP_EX
    - other -> FETCH, with illegal_op=1 this cycle
  - MEM_ADR: alu_src_a=1, alu_src_b=10, alu_opcode=11. LW -> MEM_RD, SW -> MEM_WR.
  - MEM_RD: mem_req=1, iord=1. Stays until mem_ready, then -> MEM_WB.
  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
  - MEM_WR: mem_req=1, mem_we=1, iord=1. Stays until mem_ready, then -> FETCH.
  - RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_opcode=00 -> RTYPE_WB.
  - RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - BEQ_EX: alu_src_a=1, alu_src_b=00, alu_opcode=01, pc_src=01, pc_write_en=zero -> FETCH.
  - IMM_EX: alu_src_a=1, alu_src_b=10. alu_opcode=11 for ADDI, 10 for SLTI -> IMM_WB.
  - IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
  - JUMP_EX: pc_src=10, pc_write_en=1 -> FETCH.
- Latency with zero wait states:
  - RTYPE, SW, ADDI, SLTI: 4 cycles
  - LW: 5 cycles
  - BEQ, J: 3 cycles
  - Each mem_ready-low cycle adds one cycle.
- opcode is sampled only in DECODE and MEM_ADR; IR is stable from DECODE onward.
- Undefined state encodings -> FETCH.
- mem_ready outside request states is ignored.
- rst mid-instruction aborts it: no further reg_write or mem_we after the reset edge.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (STW bits)
  - opcode localparams
  - alu_opcode localparams (ALU_OP_FUNCT, ALU_OP_SUB, ALU_OP_SLTI, ALU_OP_ADD)
  - pc_src and alu_src_b encodings
- Single module, no sub-module: a state register plus next-state and output case blocks.

Test Plan:
- Reset: rst=1 for 2 cycles mid-LW (state MEM_RD) -> state_o=FETCH, reg_write=0, mem_we=0, alu_opcode=11 throughout; first fetch follows rst release.
- RTYPE, mem_ready always 1 -> states FETCH, DECODE, RTYPE_EX, RTYPE_WB. alu_opcode=00 in RTYPE_EX; reg_write=1 with reg_dst=1 in RTYPE_WB; back at FETCH on the 5th cycle.
- LW with mem_ready low 2 cycles in FETCH and 1 in MEM_RD -> 8 cycles total. ir_write pulses exactly once. reg_write=1 with mem_to_reg=1 in MEM_WB.
- BEQ twice, zero=1 then zero=0 -> alu_opcode=01 in BEQ_EX each time. pc_write_en=1 with pc_src=01 only for zero=1.
- SLTI then J -> IMM_EX drives alu_opcode=10 and alu_src_b=10. JUMP_EX drives pc_src=10 and pc_write_en=1. J completes in 3 cycles.
- Opcode 111111 -> illegal_op pulses 1 cycle in DECODE, no reg_write or mem_req beyond fetch, next state FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: states, opcodes,
// ALU opcode handed to alu_control_unit, and datapath mux selects.
package mips_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int STATE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADR  = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ_EX   = 4'd8,
    IMM_EX   = 4'd9,
    IMM_WB   = 4'd10,
    JUMP_EX  = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_FUNCT = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_SLTI  = 2'b10;
  localparam logic [1:0] ALU_OP_ADD   = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mips_main_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/
// writeback, stalling on the unified memory's mem_ready handshake.
module mips_main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           ir_write,
  output logic           pc_write_en,
  output logic [1:0]     pc_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_opcode,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           illegal_op,
  output logic [STW-1:0] state_o
);

  state_t r_state;
  state_t w_nextState;
  logic   r_isSlti;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FETCH;
      r_isSlti <= 1'b0;
    end else begin
      r_state <= w_nextState;
      // Latch the immediate flavour in DECODE so IMM_EX needs no opcode look.
      if (r_state == DECODE) r_isSlti <= (opcode == OP_SLTI);
    end
  end

  always_comb begin
    w_nextState = FETCH;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write_en = 1'b0;
    pc_src      = PC_SRC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REGB;
    alu_opcode  = ALU_OP_ADD;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal_op  = 1'b0;

    case (r_state)
      FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = SRCB_FOUR;
        ir_write    = mem_ready;
        pc_write_en = mem_ready;
        w_nextState = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW:     w_nextState = MEM_ADR;
          OP_RTYPE:         w_nextState = RTYPE_EX;
          OP_BEQ:           w_nextState = BEQ_EX;
          OP_ADDI, OP_SLTI: w_nextState = IMM_EX;
          OP_J:             w_nextState = JUMP_EX;
          default:          illegal_op  = 1'b1;
        endcase
      end
      MEM_ADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        w_nextState = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req     = 1'b1;
        iord        = 1'b1;
        w_nextState = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        iord        = 1'b1;
        w_nextState = mem_ready ? FETCH : MEM_WR;
      end
      RTYPE_EX: begin
        alu_src_a   = 1'b1;
        alu_opcode  = ALU_OP_FUNCT;
        w_nextState = RTYPE_WB;
      end
      RTYPE_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BEQ_EX: begin
        alu_src_a   = 1'b1;
        alu_opcode  = ALU_OP_SUB;
        pc_src      = PC_SRC_ALUOUT;
        pc_write_en = zero;
      end
      IMM_EX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        alu_opcode  = r_isSlti ? ALU_OP_SLTI : ALU_OP_ADD;
        w_nextState = IMM_WB;
      end
      IMM_WB: reg_write = 1'b1;
      JUMP_EX: begin
        pc_src      = PC_SRC_JUMP;
        pc_write_en = 1'b1;
      end
      default: w_nextState = FETCH;
    endcase

    // Reset overrides everything so an aborted instruction cannot write.
    if (rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write_en = 1'b0;
      pc_src      = PC_SRC_ALU;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_REGB;
      alu_opcode  = ALU_OP_ADD;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

  assign state_o = rst ? STW'(FETCH) : STW'(r_state);

endmodule
